cdr_phase_ctrl: RTL and testbench

Phase controller for the clock-recovery path. It consumes the one-cycle active-low edge pulse produced by the data edge detector and runs an oversampling phase counter. It hard-aligns that counter during acquisition and trims it by ±1 cycle per edge once tracked. It emits the mid-bit sample strobe, the recovered data bit and a lock indication to the downstream deserializer.

---
 rtl/cdr_pkg.sv | 28 ++
 rtl/cdr_phase_cnt.sv | 80 ++++++++
 rtl/cdr_phase_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_cdr_phase_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/cdr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cdr_pkg
// Description : Shared types and default constants for the CDR phase control.
// Revision    : 1.0 - initial release
// ============================================================================
package cdr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACQ   = 2'd1,
        TRACK = 2'd2
    } cdr_state_e;

    typedef enum logic [1:0] {
        ON    = 2'd0,
        LATE  = 2'd1,
        AMBIG = 2'd2,
        EARLY = 2'd3
    } edge_class_e;

    localparam int unsigned c_osr_default         = 8;
    localparam int unsigned c_lock_cnt_default    = 16;
    localparam int unsigned c_err_cnt_default     = 4;
    localparam int unsigned c_timeout_cyc_default = 256;

endpackage
`default_nettype wire

// File: rtl/cdr_phase_cnt.sv
`default_nettype none
// ============================================================================
// Module      : cdr_phase_cnt
// Description : Oversampling phase counter with clear/load-1/hold/skip controls
//               and classifier of the current phase as an edge position.
// Revision    : 1.0 - initial release
// ============================================================================
module cdr_phase_cnt
    import cdr_pkg::*;
#(
    parameter  int unsigned OSR = c_osr_default,
    localparam int unsigned PW  = $clog2(OSR)
) (
    input  logic          clk_ref_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          run_i,
    input  logic          load1_i,
    input  logic          hold_i,
    input  logic          skip_i,
    output logic [PW-1:0] ph_o,
    output edge_class_e   class_o
);

    localparam logic [PW-1:0] c_last    = PW'(OSR - 1);
    localparam logic [PW-1:0] c_last_m1 = PW'(OSR - 2);
    localparam logic [PW-1:0] c_half    = PW'(OSR / 2);

    logic [PW-1:0] ph_q;
    logic [PW-1:0] ph_d;
    logic [PW-1:0] w_inc;
    logic [PW-1:0] w_skip;

    always_comb begin
        w_inc = (ph_q == c_last) ? '0 : ph_q + PW'(1);
        // Explicit wrap keeps the skip correct for non-power-of-two ratios.
        if (ph_q == c_last) begin
            w_skip = PW'(1);
        end else if (ph_q == c_last_m1) begin
            w_skip = '0;
        end else begin
            w_skip = ph_q + PW'(2);
        end

        ph_d = ph_q;
        if (clr_i) begin
            ph_d = '0;
        end else if (load1_i) begin
            ph_d = PW'(1);
        end else if (hold_i) begin
            ph_d = ph_q;
        end else if (skip_i) begin
            ph_d = w_skip;
        end else if (run_i) begin
            ph_d = w_inc;
        end

        if (ph_q == '0) begin
            class_o = ON;
        end else if (ph_q < c_half) begin
            class_o = LATE;
        end else if (ph_q == c_half) begin
            class_o = AMBIG;
        end else begin
            class_o = EARLY;
        end
    end

    always_ff @(posedge clk_ref_i) begin
        if (rst_i) begin
            ph_q <= '0;
        end else begin
            ph_q <= ph_d;
        end
    end

    assign ph_o = ph_q;

endmodule
`default_nettype wire

// File: rtl/cdr_phase_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cdr_phase_ctrl
// Description : CDR phase controller: acquisition/tracking FSM, lock, error and
//               timeout counters, mid-bit sampling of the recovered data.
// Revision    : 1.0 - initial release
// ============================================================================
module cdr_phase_ctrl
    import cdr_pkg::*;
#(
    parameter int unsigned OSR         = c_osr_default,
    parameter int unsigned LOCK_CNT    = c_lock_cnt_default,
    parameter int unsigned ERR_CNT     = c_err_cnt_default,
    parameter int unsigned TIMEOUT_CYC = c_timeout_cyc_default
) (
    input  logic                    clk_ref_i,
    input  logic                    rst_i,
    input  logic                    en_i,
    input  logic                    edge_out_bar_i,
    input  logic                    data_i,
    output logic                    sample_en_o,
    output logic                    data_o,
    output logic                    data_valid_o,
    output logic                    locked_o,
    output logic [$clog2(OSR)-1:0]  phase_o
);

    localparam int unsigned PW = $clog2(OSR);
    localparam int unsigned GW = $clog2(LOCK_CNT + 1);
    localparam int unsigned EW = $clog2(ERR_CNT + 1);
    localparam int unsigned IW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [PW-1:0] c_half     = PW'(OSR / 2);
    localparam logic [PW-1:0] c_last     = PW'(OSR - 1);
    localparam logic [GW-1:0] c_good_max = GW'(LOCK_CNT);
    localparam logic [EW-1:0] c_err_max  = EW'(ERR_CNT);
    localparam logic [IW-1:0] c_idle_max = IW'(TIMEOUT_CYC);

    cdr_state_e    state_q, state_d;
    logic [GW-1:0] good_cnt_q, good_cnt_d;
    logic [EW-1:0] err_cnt_q, err_cnt_d;
    logic [IW-1:0] idle_cnt_q, idle_cnt_d;
    logic          data_q, data_d;
    logic          data_valid_q, data_valid_d;

    logic          w_edge, w_err_ok, w_sample, w_timeout;
    logic [IW-1:0] w_idle_inc;
    logic [PW-1:0] w_ph;
    edge_class_e   w_class;
    logic          w_clr, w_run, w_load1, w_hold, w_skip;

    cdr_phase_cnt #(
        .OSR (OSR)
    ) u_phase_cnt (
        .clk_ref_i (clk_ref_i),
        .rst_i     (rst_i),
        .clr_i     (w_clr),
        .run_i     (w_run),
        .load1_i   (w_load1),
        .hold_i    (w_hold),
        .skip_i    (w_skip),
        .ph_o      (w_ph),
        .class_o   (w_class)
    );

    assign w_edge     = en_i & ~edge_out_bar_i;
    assign w_err_ok   = (w_ph == '0) || (w_ph == PW'(1)) || (w_ph == c_last);
    assign w_idle_inc = (idle_cnt_q == c_idle_max) ? idle_cnt_q : idle_cnt_q + IW'(1);
    // Fires on the edgeless cycle that brings the idle count up to the limit.
    assign w_timeout  = (w_idle_inc == c_idle_max);
    assign w_sample   = ((state_q == ACQ) || (state_q == TRACK)) && (w_ph == c_half);

    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        err_cnt_d  = err_cnt_q;
        idle_cnt_d = idle_cnt_q;
        w_clr      = 1'b0;
        w_run      = 1'b0;
        w_load1    = 1'b0;
        w_hold     = 1'b0;
        w_skip     = 1'b0;

        case (state_q)
            IDLE: begin
                w_clr      = 1'b1;
                good_cnt_d = '0;
                err_cnt_d  = '0;
                idle_cnt_d = '0;
                if (en_i) begin
                    state_d = ACQ;
                end
            end
            ACQ: begin
                w_run = 1'b1;
                if (w_edge) begin
                    w_load1    = 1'b1;
                    idle_cnt_d = '0;
                    if (w_class == ON) begin
                        if (good_cnt_q != c_good_max) begin
                            good_cnt_d = good_cnt_q + GW'(1);
                        end
                        if (good_cnt_d == c_good_max) begin
                            state_d   = TRACK;
                            err_cnt_d = '0;
                        end
                    end else begin
                        good_cnt_d = '0;
                    end
                end else if (w_timeout) begin
                    good_cnt_d = '0;
                    err_cnt_d  = '0;
                    idle_cnt_d = '0;
                end else begin
                    idle_cnt_d = w_idle_inc;
                end
            end
            TRACK: begin
                w_run = 1'b1;
                if (w_edge) begin
                    idle_cnt_d = '0;
                    w_hold     = (w_class == LATE);
                    w_skip     = (w_class == EARLY);
                    if (w_err_ok) begin
                        err_cnt_d = '0;
                    end else if (err_cnt_q != c_err_max) begin
                        err_cnt_d = err_cnt_q + EW'(1);
                    end
                    if (err_cnt_d == c_err_max) begin
                        state_d    = ACQ;
                        good_cnt_d = '0;
                        err_cnt_d  = '0;
                        idle_cnt_d = '0;
                    end
                end else if (w_timeout) begin
                    state_d    = ACQ;
                    good_cnt_d = '0;
                    err_cnt_d  = '0;
                    idle_cnt_d = '0;
                end else begin
                    idle_cnt_d = w_idle_inc;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (!en_i) begin
            state_d    = IDLE;
            good_cnt_d = '0;
            err_cnt_d  = '0;
            idle_cnt_d = '0;
            w_clr      = 1'b1;
        end

        data_d       = data_q;
        data_valid_d = 1'b0;
        if (w_sample) begin
            data_d       = data_i;
            data_valid_d = (state_q == TRACK);
        end
        if (state_d == IDLE) begin
            data_d       = 1'b0;
            data_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_ref_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            good_cnt_q   <= '0;
            err_cnt_q    <= '0;
            idle_cnt_q   <= '0;
            data_q       <= 1'b0;
            data_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            good_cnt_q   <= good_cnt_d;
            err_cnt_q    <= err_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
        end
    end

    assign sample_en_o  = w_sample;
    assign data_o       = data_q;
    assign data_valid_o = data_valid_q;
    assign locked_o     = (state_q == TRACK);
    assign phase_o      = w_ph;

endmodule
`default_nettype wire

// File: tb/tb_cdr_phase_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cdr_phase_ctrl
// Description : Directed scoreboard bench for cdr_phase_ctrl (OSR=8, LOCK=4,
//               ERR=4, TIMEOUT=32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cdr_phase_ctrl;

    localparam int unsigned OSR         = 8;
    localparam int unsigned LOCK_CNT    = 4;
    localparam int unsigned ERR_CNT     = 4;
    localparam int unsigned TIMEOUT_CYC = 32;

    logic       clk_ref_i;
    logic       rst_i;
    logic       en_i;
    logic       edge_out_bar_i;
    logic       data_i;
    logic       sample_en_o;
    logic       data_o;
    logic       data_valid_o;
    logic       locked_o;
    logic [2:0] phase_o;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_valid = 0;
    int   saved_valid;
    logic exp_q[$];
    logic prev;

    cdr_phase_ctrl #(
        .OSR         (OSR),
        .LOCK_CNT    (LOCK_CNT),
        .ERR_CNT     (ERR_CNT),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk_ref_i      (clk_ref_i),
        .rst_i          (rst_i),
        .en_i           (en_i),
        .edge_out_bar_i (edge_out_bar_i),
        .data_i         (data_i),
        .sample_en_o    (sample_en_o),
        .data_o         (data_o),
        .data_valid_o   (data_valid_o),
        .locked_o       (locked_o),
        .phase_o        (phase_o)
    );

    initial begin
        clk_ref_i = 1'b0;
        forever #5 clk_ref_i = ~clk_ref_i;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    // Inputs change just after the active edge; outputs are read after it settles.
    task automatic cyc(input logic eb, input logic d);
        edge_out_bar_i = eb;
        data_i         = d;
        @(posedge clk_ref_i);
        #1;
    endtask

    task automatic send_bit(input int period, input int npush, input int exp_ph, input int exp_lock);
        logic b;
        b = ~prev;
        for (int i = 0; i < npush; i++) exp_q.push_back(b);
        cyc(1'b0, b);
        if (exp_ph >= 0)   chk("phase_after_edge", int'(phase_o), exp_ph);
        if (exp_lock >= 0) chk("locked_after_edge", int'(locked_o), exp_lock);
        for (int i = 1; i < period; i++) cyc(1'b1, b);
        prev = b;
    endtask

    // Drop to IDLE, re-enable, misaligned first edge, then 4 on-phase edges.
    task automatic lock_up();
        en_i = 1'b0;
        cyc(1'b1, prev);
        en_i = 1'b1;
        for (int i = 0; i < 4; i++) cyc(1'b1, prev);
        for (int i = 0; i < 4; i++) send_bit(8, 0, 1, 0);
        send_bit(8, 1, 1, 1);
    endtask

    always @(negedge clk_ref_i) begin
        if (rst_i === 1'b0 && sample_en_o === 1'b1)
            chk("sample_phase", int'(phase_o), 4);
        if (data_valid_o === 1'b1) begin
            n_valid++;
            if (exp_q.size() == 0)
                chk("valid_without_expect", int'(data_valid_o), 0);
            else
                chk("data_o", int'(data_o), int'(exp_q.pop_front()));
        end
    end

    initial begin
        rst_i          = 1'b1;
        en_i           = 1'b0;
        edge_out_bar_i = 1'b1;
        data_i         = 1'b0;
        prev           = 1'b0;
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        chk("rst_sample_en", int'(sample_en_o), 0);
        chk("rst_data_o", int'(data_o), 0);
        chk("rst_data_valid", int'(data_valid_o), 0);
        chk("rst_locked", int'(locked_o), 0);
        chk("rst_phase", int'(phase_o), 0);
        rst_i = 1'b0;

        // Ideal stream, then drifting bit periods (late holds, early skips)
        lock_up();
        send_bit(8, 1, 1, 1);
        send_bit(8, 1, 1, 1);
        repeat (4) send_bit(9, 1, 1, 1);
        repeat (4) send_bit(7, 1, 1, 1);
        send_bit(8, 1, 1, 1);

        // Four consecutive edges at p=3 drop lock, then re-acquire
        send_bit(11, 1, 1, 1);
        repeat (3) send_bit(9, 1, 3, 1);
        send_bit(8, 0, -1, 0);
        repeat (4) send_bit(8, 0, 1, 0);
        send_bit(8, 1, 1, 1);

        // Edge exactly on the timeout cycle keeps lock; next stretch times out
        send_bit(32, 4, 1, 1);
        chk("locked_before_timeout", int'(locked_o), 1);
        send_bit(32, 4, 1, 1);
        chk("locked_idle_restarted", int'(locked_o), 1);
        cyc(1'b1, prev);
        chk("locked_after_timeout", int'(locked_o), 0);
        chk("phase_runs_in_acq", int'(phase_o), 1);
        saved_valid = n_valid;
        repeat (16) cyc(1'b1, prev);
        chk("no_valid_after_timeout", n_valid, saved_valid);
        chk("still_unlocked", int'(locked_o), 0);

        // Synchronous reset mid-TRACK
        lock_up();
        if (prev == 1'b0) send_bit(8, 1, 1, 1);
        rst_i = 1'b1;
        cyc(1'b1, prev);
        rst_i = 1'b0;
        chk("midrst_locked", int'(locked_o), 0);
        chk("midrst_phase", int'(phase_o), 0);
        chk("midrst_sample_en", int'(sample_en_o), 0);
        chk("midrst_data_o", int'(data_o), 0);
        chk("midrst_data_valid", int'(data_valid_o), 0);

        // Enable low forces IDLE; re-enable restarts the phase count in ACQ
        lock_up();
        if (prev == 1'b0) send_bit(8, 1, 1, 1);
        en_i = 1'b0;
        cyc(1'b1, prev);
        chk("en_low_locked", int'(locked_o), 0);
        chk("en_low_phase", int'(phase_o), 0);
        chk("en_low_data_o", int'(data_o), 0);
        chk("en_low_data_valid", int'(data_valid_o), 0);
        en_i = 1'b1;
        cyc(1'b1, prev);
        chk("reenable_phase0", int'(phase_o), 0);
        cyc(1'b1, prev);
        cyc(1'b1, prev);
        chk("reenable_phase2", int'(phase_o), 2);
        chk("reenable_locked", int'(locked_o), 0);

        chk("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
